// File: rtl/start_token_consumer.sv
// start_token_consumer: turns start-FIFO tokens into ap_start/ap_ready handshakes and tracks PE runs in flight
module start_token_consumer #(
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_empty_n,
  output logic             start_read,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             enable,
  output logic             busy,
  output logic [CNT_W-1:0] accepted_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic             err_underflow
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] MAX_V = IW'(MAX_INFLIGHT);
  typedef enum logic [1:0] {IDLE, ARMED, FULL} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0] accepted_q, accepted_d, done_q, done_d;
  logic             ap_start_q, ap_start_d, busy_q, busy_d, err_q, err_d;
  logic             accept;
  assign accept        = ap_start_q && ap_ready && start_empty_n;
  assign start_read    = accept;
  assign ap_start      = ap_start_q;
  assign busy          = busy_q;
  assign accepted_cnt  = accepted_q;
  assign done_cnt      = done_q;
  assign err_underflow = err_q;
  // Next-state: arm on a visible token when there is room, leave ARMED only on accept (one bubble after), park in FULL at the limit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = (enable && start_empty_n && inflight_q < MAX_V) ? ARMED :
                         (inflight_q == MAX_V) ? FULL : IDLE;
      ARMED:   state_d = accept ? IDLE : ARMED;
      FULL:    state_d = (inflight_q < MAX_V) ? IDLE : FULL;
      default: state_d = IDLE;
    endcase
    inflight_d = (accept && !ap_done) ? inflight_q + IW'(1) :
                 (!accept && ap_done && inflight_q != '0) ? inflight_q - IW'(1) : inflight_q;
    accepted_d = accept  ? accepted_q + CNT_W'(1) : accepted_q;
    done_d     = ap_done ? done_q + CNT_W'(1) : done_q;
    err_d      = err_q || (ap_done && inflight_q == '0);
    ap_start_d = state_d == ARMED;
    busy_d     = inflight_d != '0 || state_d == ARMED;
  end
  // State and registered outputs; async reset drops ap_start immediately so the token stays in the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      inflight_q <= '0;
      accepted_q <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      ap_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      accepted_q <= accepted_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ap_start_q <= ap_start_d;
      busy_q     <= busy_d;
    end
  end
endmodule

// File: tb/tb_start_token_consumer.sv
// tb_start_token_consumer: directed checks of the start token consumer with MAX_INFLIGHT=2, CNT_W=4
module tb_start_token_consumer;
  logic       clk = 1'b0;
  logic       reset, start_empty_n, ap_ready, ap_done, enable;
  logic       start_read, ap_start, busy, err_underflow;
  logic [3:0] accepted_cnt, done_cnt;
  int         errs = 0, checks = 0, tokens = 0, pops = 0;
  logic       any, held, found;
  start_token_consumer #(.MAX_INFLIGHT(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start_empty_n(start_empty_n), .start_read(start_read),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .enable(enable),
    .busy(busy), .accepted_cnt(accepted_cnt), .done_cnt(done_cnt), .err_underflow(err_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    logic pop;
    #3;
    pop = start_read;
    @(posedge clk);
    #1;
    if (pop) begin
      pops++;
      if (tokens > 0) tokens--;
    end
    start_empty_n = tokens != 0;
  endtask
  task automatic load(input int n);
    tokens = n;
    start_empty_n = n != 0;
  endtask
  task automatic rst;
    reset = 1'b1;
    ap_ready = 1'b0;
    ap_done = 1'b0;
    enable = 1'b0;
    load(0);
    pops = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    rst();
    chk("rst_ap_start", 32'(ap_start), 0);
    chk("rst_start_read", 32'(start_read), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_acc", 32'(accepted_cnt), 0);
    chk("rst_done", 32'(done_cnt), 0);
    chk("rst_err", 32'(err_underflow), 0);
    enable = 1'b1;
    any = 1'b0;
    repeat (20) begin
      tick();
      any |= ap_start | start_read | busy;
    end
    chk("idle_quiet", 32'(any), 0);
    chk("idle_acc", 32'(accepted_cnt), 0);
    rst();
    ap_ready = 1'b1;
    enable = 1'b1;
    repeat (5) tick();
    load(1);
    tick();
    chk("single_ap_start", 32'(ap_start), 1);
    chk("single_read", 32'(start_read), 1);
    chk("single_acc_pre", 32'(accepted_cnt), 0);
    tick();
    chk("single_ap_start_drop", 32'(ap_start), 0);
    chk("single_read_drop", 32'(start_read), 0);
    chk("single_acc", 32'(accepted_cnt), 1);
    chk("single_busy", 32'(busy), 1);
    repeat (5) tick();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    chk("single_done", 32'(done_cnt), 1);
    chk("single_busy_clr", 32'(busy), 0);
    chk("single_pops", 32'(pops), 1);
    rst();
    ap_ready = 1'b1;
    enable = 1'b1;
    load(4);
    repeat (12) tick();
    chk("bp_acc", 32'(accepted_cnt), 2);
    chk("bp_ap_start", 32'(ap_start), 0);
    chk("bp_tokens", 32'(tokens), 2);
    chk("bp_busy", 32'(busy), 1);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    found = 1'b0;
    repeat (3) begin
      if (start_read) found = 1'b1;
      tick();
    end
    chk("bp_third_accept", 32'(found), 1);
    chk("bp_acc3", 32'(accepted_cnt), 3);
    rst();
    enable = 1'b1;
    load(1);
    tick();
    held = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) enable = 1'b0;
      held &= ap_start;
      tick();
    end
    chk("dly_held", 32'(held), 1);
    chk("dly_no_pop", 32'(pops), 0);
    chk("dly_ap_start", 32'(ap_start), 1);
    ap_ready = 1'b1;
    #1;
    chk("dly_read", 32'(start_read), 1);
    tick();
    chk("dly_ap_start_drop", 32'(ap_start), 0);
    chk("dly_pops", 32'(pops), 1);
    chk("dly_acc", 32'(accepted_cnt), 1);
    rst();
    enable = 1'b1;
    ap_ready = 1'b1;
    load(1);
    tick();
    chk("ar_armed", 32'(start_read), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_ap_start", 32'(ap_start), 0);
    chk("ar_read", 32'(start_read), 0);
    rst();
    enable = 1'b1;
    ap_ready = 1'b1;
    load(1);
    tick();
    tick();
    chk("sim_acc1", 32'(accepted_cnt), 1);
    load(1);
    tick();
    chk("sim_armed", 32'(start_read), 1);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    chk("sim_acc2", 32'(accepted_cnt), 2);
    chk("sim_done1", 32'(done_cnt), 1);
    chk("sim_busy", 32'(busy), 1);
    chk("sim_err", 32'(err_underflow), 0);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    chk("sim_done2", 32'(done_cnt), 2);
    chk("sim_busy_clr", 32'(busy), 0);
    chk("sim_err_still0", 32'(err_underflow), 0);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    chk("uf_err", 32'(err_underflow), 1);
    chk("uf_done", 32'(done_cnt), 3);
    chk("uf_busy", 32'(busy), 0);
    repeat (5) tick();
    chk("uf_sticky", 32'(err_underflow), 1);
    rst();
    enable = 1'b1;
    ap_ready = 1'b1;
    repeat (17) begin
      load(1);
      tick();
      tick();
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
    end
    chk("wrap_acc", 32'(accepted_cnt), 1);
    chk("wrap_done", 32'(done_cnt), 1);
    chk("wrap_err", 32'(err_underflow), 0);
    chk("wrap_busy", 32'(busy), 0);
    chk("wrap_pops", 32'(pops), 17);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/start_token_consumer.md
# start_token_consumer

Read-side controller for a start-propagation channel between two dataflow stages of the linear-layer kernel. It pops start tokens from the empty_n/read port of an upstream start FIFO and converts each token into one ap_start/ap_ready handshake on a downstream PE. It tracks PEs in flight until their ap_done, limits outstanding runs, and exposes token/run counters plus a sticky protocol-error flag for debug.

## Interface
Parameters:
- MAX_INFLIGHT, default 2: maximum accepted-but-not-done PE runs, range 1..15.
- CNT_W, default 16: width of the accepted and done counters.

Ports:
- clk  in  1  single clock; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-high; it clears all state immediately.
- start_empty_n  in  1  high when the start FIFO holds at least one token.
- start_read  out  1  one-cycle token pop strobe to the start FIFO.
- ap_start  out  1  start request to the downstream PE.
- ap_ready  in  1  the PE accepts the current start.
- ap_done  in  1  one-cycle pulse when a PE run completes.
- enable  in  1  gates new starts; it never affects runs already in flight.
- busy  out  1  high when inflight != 0 or state is ARMED.
- accepted_cnt  out  CNT_W  number of tokens popped; wraps modulo 2^CNT_W.
- done_cnt  out  CNT_W  number of ap_done pulses counted; wraps modulo 2^CNT_W.
- err_underflow  out  1  sticky; set when ap_done arrives while inflight == 0.

## Operation
- Internal state: FSM {IDLE, ARMED, FULL} and an inflight counter of width clog2(MAX_INFLIGHT+1).
- IDLE:
  - go to ARMED when enable && start_empty_n && inflight < MAX_INFLIGHT.
  - otherwise go to FULL when inflight == MAX_INFLIGHT.
  - otherwise stay in IDLE.
- ARMED:
  - ap_start = 1, registered: it is high exactly while the state is ARMED.
  - accept = ap_start && ap_ready && start_empty_n.
  - start_read = accept, combinational, so it is a single-cycle pulse.
  - on accept, go to IDLE; this gives one bubble cycle so the FIFO can update empty_n.
  - with no accept, ARMED holds. Neither enable deasserting nor start_empty_n dropping withdraws ap_start once raised (AP handshake rule).
- FULL: go to IDLE when inflight < MAX_INFLIGHT.
- inflight update:
  - +1 on accept, -1 on ap_done.
  - both in the same cycle leaves it unchanged.
  - ap_done with inflight == 0 leaves it at 0 and sets err_underflow.
- accepted_cnt increments on accept and done_cnt increments on every ap_done, including the underflow case. Both wrap silently.
- err_underflow clears only on reset.
- ap_ready while ap_start == 0 is ignored.

## Timing
- Reset values: ap_start=0, start_read=0, busy=0, accepted_cnt=0, done_cnt=0, err_underflow=0, state=IDLE, inflight=0.
- Token visible in IDLE at cycle N gives ap_start=1 at N+1.
- With ap_ready high at N+1, start_read pulses at N+1 and ap_start=0 at N+2.
- Peak throughput: one accept per 2 cycles.
- The inflight decrement from ap_done at cycle M is visible at M+1. In FULL, ap_start can rise at M+3 at the earliest (FULL→IDLE at M+2, IDLE→ARMED at M+3).
- Counters and busy are registered and update the cycle after the event.
- Reset asserted mid-handshake drops ap_start and start_read within the same cycle (asynchronously). The token stays in the FIFO.

## Test plan
- Reset then idle: start_empty_n=0 for 20 cycles → ap_start, start_read and busy stay 0; counters stay 0.
- Single token with ap_ready tied high: empty_n rises at cycle 5 → ap_start=1 at cycle 6, start_read pulses at 6 only, accepted_cnt=1 at 7; ap_done at 12 → done_cnt=1 and busy=0 at 13.
- Back-pressure, MAX_INFLIGHT=2: 4 tokens queued, ap_ready=1, no ap_done → exactly 2 accepts, then FULL with ap_start=0. One ap_done pulse → the third accept follows within 3 cycles.
- Delayed ready: ap_ready held low 7 cycles while ARMED and enable dropped at cycle 2 → ap_start remains 1 throughout, and start_read pulses once when ap_ready rises.
- Simultaneous accept and ap_done at inflight=1 → inflight stays 1, both counters +1. Then ap_done with inflight=0 → err_underflow=1 and remains set.
- Wrap-around, CNT_W=4: 17 accepted runs → accepted_cnt=1 and done_cnt=1, no error raised.
